// File: rtl/cache_refill_engine.sv
// Cache miss/eviction engine: optional write-back of a dirty victim followed by an
// optional refill read, against a flop-based 64x32 backing store with fixed latency.
module cache_refill_engine #(
    parameter int unsigned MEM_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_valid,
    output logic        miss_ready,
    input  logic [5:0]  miss_addr,
    input  logic        fill_en,
    input  logic        wb_en,
    input  logic [5:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        fill_valid,
    output logic [31:0] fill_data,
    output logic [5:0]  fill_addr
);

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0]  LAT_M1    = CNT_W'(MEM_LATENCY - 1);
    localparam logic [DATA_W-1:0] STORE_RST = 32'hDEADBE00;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WB   = 2'd1;
    localparam logic [1:0] RD   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              accept_c;
    logic              wb_write_c;
    logic              rd_load_c;

    logic              cap_fill;
    logic              cap_wb;
    logic [5:0]        cap_wb_addr;
    logic [DATA_W-1:0] cap_wb_data;

    logic [DATA_W-1:0] store [DEPTH];

    // State and latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter and store-strobe decode
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept_c   = 1'b0;
        wb_write_c = 1'b0;
        rd_load_c  = 1'b0;
        case (state)
            IDLE: begin
                if (miss_valid) begin
                    accept_c = 1'b1;
                    if (wb_en) begin
                        state_nxt = WB;
                        cnt_nxt   = LAT_M1;
                    end else if (fill_en) begin
                        state_nxt = RD;
                        cnt_nxt   = LAT_M1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            WB: begin
                if (cnt == '0) begin
                    wb_write_c = 1'b1;
                    if (cap_fill) begin
                        state_nxt = RD;
                        cnt_nxt   = LAT_M1;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RD: begin
                if (cnt == '0) begin
                    rd_load_c = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture; fill_addr doubles as the captured miss address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_fill    <= 1'b0;
            cap_wb      <= 1'b0;
            cap_wb_addr <= '0;
            cap_wb_data <= '0;
            fill_addr   <= '0;
        end else if (accept_c) begin
            cap_fill    <= fill_en;
            cap_wb      <= wb_en;
            cap_wb_addr <= wb_addr;
            cap_wb_data <= wb_data;
            fill_addr   <= miss_addr;
        end
    end

    // Registered handshake/completion outputs, decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_ready <= 1'b1;
            fill_valid <= 1'b0;
        end else begin
            miss_ready <= (state_nxt == IDLE);
            fill_valid <= (state_nxt == DONE);
        end
    end

    // Refill data holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_data <= '0;
        end else if (rd_load_c) begin
            fill_data <= store[fill_addr];
        end
    end

    // Backing store; reset pattern tags each word with its own index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= STORE_RST | DATA_W'(i);
            end
        end else if (wb_write_c && cap_wb) begin
            store[cap_wb_addr] <= cap_wb_data;
        end
    end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine with a transaction-level reference model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_cache_refill_engine;

    localparam int unsigned L = 3;

    logic        clk;
    logic        rst_n;
    logic        miss_valid;
    logic        miss_ready;
    logic [5:0]  miss_addr;
    logic        fill_en;
    logic        wb_en;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic [5:0]  fill_addr;

    int n_checks = 0;
    int n_errors = 0;

    cache_refill_engine #(.MEM_LATENCY(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .miss_valid (miss_valid),
        .miss_ready (miss_ready),
        .miss_addr  (miss_addr),
        .fill_en    (fill_en),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .fill_valid (fill_valid),
        .fill_data  (fill_data),
        .fill_addr  (fill_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending transaction with a remaining-cycle count
    logic [31:0] m_store [64];
    logic        m_busy;
    logic        m_valid;
    int          m_rem;
    logic [31:0] m_data;
    logic [5:0]  m_addr;
    logic        r_fill, r_wb;
    logic [5:0]  r_wb_addr;
    logic [31:0] r_wb_data;
    int          m_accepts = 0;
    logic        chk_en = 1'b0;

    task automatic m_complete();
        m_busy  = 1'b0;
        m_valid = 1'b1;
        if (r_wb) m_store[r_wb_addr] = r_wb_data;
        if (r_fill) m_data = m_store[m_addr];
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_store[i] = 32'hDEADBE00 | 32'(i);
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_rem   = 0;
            m_data  = '0;
            m_addr  = '0;
        end else if (m_valid) begin
            m_valid = 1'b0;
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) m_complete();
        end else if (miss_valid) begin
            m_accepts++;
            r_fill    = fill_en;
            r_wb      = wb_en;
            r_wb_addr = wb_addr;
            r_wb_data = wb_data;
            m_addr    = miss_addr;
            m_rem     = (wb_en ? int'(L) : 0) + (fill_en ? int'(L) : 0);
            m_busy    = 1'b1;
            if (m_rem == 0) m_complete();
        end
    end

    // Per-cycle compare against the model
    int pulses = 0;
    always @(negedge clk) begin
        if (rst_n && fill_valid) pulses++;
        if (chk_en) begin
            check("miss_ready", 32'(miss_ready), 32'(!m_busy && !m_valid));
            check("fill_valid", 32'(fill_valid), 32'(m_valid));
            check("fill_data", fill_data, m_data);
            if (m_valid) check("fill_addr", 32'(fill_addr), 32'(m_addr));
        end
    end

    task automatic idle_inputs();
        miss_valid = 1'b0;
        miss_addr  = '0;
        fill_en    = 1'b0;
        wb_en      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
    endtask

    // Issue one request; return cycles to fill_valid (0 on timeout)
    task automatic run_req(input logic wb, input logic fl, input logic [5:0] waddr,
                           input logic [31:0] wdata, input logic [5:0] maddr,
                           output int lat, output int busy_cycles);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!miss_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        #1;
        miss_valid = 1'b1;
        wb_en      = wb;
        fill_en    = fl;
        wb_addr    = waddr;
        wb_data    = wdata;
        miss_addr  = maddr;
        @(posedge clk);
        #1;
        idle_inputs();
        lat = 0;
        busy_cycles = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (fill_valid) begin
                lat = n;
                break;
            end
            if (!miss_ready) busy_cycles++;
        end
        if (lat == 0) check("fill_valid_timeout", 32'(0), 32'(1));
    endtask

    int lat, busy;
    int pulses0, accepts0, seen;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miss_ready", 32'(miss_ready), 32'(1));
        check("rst_fill_valid", 32'(fill_valid), 32'(0));
        check("rst_fill_data", fill_data, 32'h0);
        check("rst_fill_addr", 32'(fill_addr), 32'h0);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Refill only
        run_req(1'b0, 1'b1, 6'h00, 32'h0, 6'h05, lat, busy);
        check("refill_lat", 32'(lat), 32'd4);
        check("refill_busy", 32'(busy), 32'd3);
        check("refill_data", fill_data, 32'hDEADBE05);
        check("refill_addr", 32'(fill_addr), 32'h05);

        // Write-back then refill of the same address
        run_req(1'b1, 1'b1, 6'h2A, 32'hCAFEBABE, 6'h2A, lat, busy);
        check("wbrd_lat", 32'(lat), 32'd7);
        check("wbrd_data", fill_data, 32'hCAFEBABE);

        // Write-back only: fill_data holds
        run_req(1'b1, 1'b0, 6'h01, 32'h12345678, 6'h11, lat, busy);
        check("wb_lat", 32'(lat), 32'd4);
        check("wb_data_hold", fill_data, 32'hCAFEBABE);
        check("wb_fill_addr", 32'(fill_addr), 32'h11);
        run_req(1'b0, 1'b1, 6'h00, 32'h0, 6'h01, lat, busy);
        check("wb_readback", fill_data, 32'h12345678);

        // Null request
        run_req(1'b0, 1'b0, 6'h3F, 32'hFFFFFFFF, 6'h3C, lat, busy);
        check("null_lat", 32'(lat), 32'd1);
        check("null_data_hold", fill_data, 32'h12345678);
        @(negedge clk);
        check("null_ready_after", 32'(miss_ready), 32'd1);

        // miss_valid held high with inputs changing every cycle
        pulses0  = pulses;
        accepts0 = m_accepts;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            miss_valid = 1'b1;
            wb_en      = i[0];
            fill_en    = i[1] ^ i[2];
            wb_addr    = 6'(i * 7);
            wb_data    = 32'hA5A50000 + 32'(i);
            miss_addr  = 6'(i * 3);
        end
        @(posedge clk);
        #1 idle_inputs();
        repeat (15) @(negedge clk);
        check("hold_accepts_nonzero", 32'(m_accepts - accepts0 > 5), 32'd1);
        check("hold_one_pulse_each", 32'(pulses - pulses0), 32'(m_accepts - accepts0));

        // Reset during write-back of word 3
        @(negedge clk);
        #1;
        miss_valid = 1'b1;
        wb_en      = 1'b1;
        fill_en    = 1'b0;
        wb_addr    = 6'h03;
        wb_data    = 32'h55AA55AA;
        miss_addr  = 6'h03;
        @(posedge clk);
        #1 idle_inputs();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (fill_valid) seen++;
        end
        check("abort_no_pulse", 32'(seen), 32'd0);
        run_req(1'b0, 1'b1, 6'h00, 32'h0, 6'h03, lat, busy);
        check("abort_readback", fill_data, 32'hDEADBE03);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cache_refill_engine.md
CACHE_REFILL_ENGINE -- requirements
Module: cache_refill_engine

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 3, giving backing-store access cycles per operation; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port miss_valid  input  1  cache presents a miss/eviction request.
REQ-005 SHALL have port miss_ready  output  1  engine idle and able to accept a request.
REQ-006 SHALL have port miss_addr  input  6  word address (cpu_addr[7:2]) to refill.
REQ-007 SHALL have port fill_en  input  1  request needs a refill read.
REQ-008 SHALL have port wb_en  input  1  request carries a dirty victim to write back.
REQ-009 SHALL have port wb_addr  input  6  word address of the victim.
REQ-010 SHALL have port wb_data  input  32  victim data.
REQ-011 SHALL have port fill_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port fill_data  output  32  refill data, valid while fill_valid=1.
REQ-013 SHALL have port fill_addr  output  6  captured miss_addr of the completing request.

Function
REQ-014 SHALL contain a 64x32 backing store built from flops, indexed by 6-bit word address.
REQ-015 SHALL implement FSM states IDLE, WB, RD, DONE; miss_ready SHALL be 1 exactly when state=IDLE.
REQ-016 SHALL accept a request on an edge where miss_valid=1 and miss_ready=1, capturing miss_addr, fill_en, wb_en, wb_addr and wb_data; inputs in other cycles are ignored.
REQ-017 On acceptance SHALL go to WB if wb_en=1, else RD if fill_en=1, else DONE; the 4-bit latency counter SHALL load MEM_LATENCY-1 on entry to WB or RD.
REQ-018 In WB and RD the counter SHALL decrement each edge; on the edge where it is 0 the operation completes, so each state lasts exactly MEM_LATENCY cycles.
REQ-019 WB completion SHALL write captured wb_data to store[wb_addr], then go to RD if fill_en=1, else DONE.
REQ-020 RD completion SHALL load fill_data <= store[miss_addr] and go to DONE.
REQ-021 In RD, the read SHALL observe a write-back completed earlier in the same request (wb_addr = miss_addr returns wb_data).
REQ-022 In DONE, fill_valid SHALL be 1 for exactly one cycle with fill_addr = captured miss_addr; the next edge SHALL return to IDLE, with no backpressure on fill_valid.
REQ-023 Latency from the accepting edge to the fill_valid cycle SHALL be 2*MEM_LATENCY+1 cycles for wb+fill, MEM_LATENCY+1 for a single operation, and 1 cycle when neither is requested.
REQ-024 With fill_en=0, fill_data SHALL hold its previous value while fill_valid pulses.
REQ-025 Back-to-back requests SHALL be possible: the earliest next acceptance is the edge after DONE, when miss_valid is already high.

Reset
REQ-026 While rst_n=0: state=IDLE, counter=0, fill_valid=0, fill_data=0, fill_addr=0, so miss_ready=1.
REQ-027 While rst_n=0, store word i SHALL reset to 32'hDEADBE00 | i (bits 5:0 = i).
REQ-028 Reset asserted mid-operation SHALL abort the request immediately; the pending write-back is lost and no fill_valid is produced.

Verification
REQ-029 SHALL test refill only (L=3): miss_addr=6'h05, fill_en=1, wb_en=0 -> fill_valid in the 4th cycle after acceptance with fill_data=32'hDEADBE05, fill_addr=6'h05; miss_ready=0 in the 3 preceding cycles.
REQ-030 SHALL test write-back then refill of the same address: wb_addr=miss_addr=6'h2A, wb_data=32'hCAFEBABE -> fill_valid after 7 cycles with fill_data=32'hCAFEBABE.
REQ-031 SHALL test write-back only: wb_addr=6'h01, data 32'h12345678, fill_en=0 -> fill_valid after 4 cycles with fill_data unchanged; a later refill of 6'h01 returns 32'h12345678.
REQ-032 SHALL test a null request (both enables 0) -> fill_valid on the first cycle after acceptance and miss_ready=1 the cycle after that.
REQ-033 SHALL test holding miss_valid=1 continuously with changing inputs -> inputs are captured only in cycles where miss_ready=1, and each request produces exactly one fill_valid pulse.
REQ-034 SHALL test rst_n pulsed low during WB of wb_addr=6'h03 -> no fill_valid; after reset, store[3] reads back 32'hDEADBE03.
